// File: rtl/accel_pkg.sv
// Shared accelerator constants: vector width, shared-memory depths and error codes.
package accel_pkg;

  localparam int VECTOR_WIDTH = 32;

  localparam int VEC_DEPTH = 64;
  localparam int MAT_DEPTH = 256;

  localparam logic [1:0] MEM_ERR_NONE     = 2'b00;
  localparam logic [1:0] MEM_ERR_CLEAR_WR = 2'b01;
  localparam logic [1:0] MEM_ERR_PARITY   = 2'b10;

endpackage

// File: rtl/sp_ram_rbw.sv
// Single-port RAM, read-before-write, with a registered read port that resets to zero.
module sp_ram_rbw #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; the owner clears it by sweeping.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[addr];
  end

endmodule

// File: rtl/shared_memory_bank.sv
// Vector (parity-protected) and matrix stores behind the memory controller, with a
// post-reset clear sweep, one-cycle write recovery and sticky error reporting.
module shared_memory_bank #(
  parameter int VEC_DEPTH = accel_pkg::VEC_DEPTH,
  parameter int MAT_DEPTH = accel_pkg::MAT_DEPTH,
  parameter int DATA_W    = accel_pkg::VECTOR_WIDTH,
  localparam int VEC_AW   = $clog2(VEC_DEPTH),
  localparam int MAT_AW   = $clog2(MAT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VEC_AW-1:0] mem_addr_a,
  input  logic              mem_we_a,
  input  logic [DATA_W-1:0] mem_wdata_a,
  output logic [DATA_W-1:0] mem_rdata_a,
  input  logic [MAT_AW-1:0] mem_addr_b,
  input  logic              mem_we_b,
  input  logic [1:0]        mem_wdata_b,
  output logic [1:0]        mem_rdata_b,
  output logic              mem_busy,
  output logic [1:0]        mem_error,
  input  logic              clear_req,
  input  logic              err_clear,
  input  logic              dbg_parity_flip
);

  import accel_pkg::*;

  typedef enum logic [1:0] {ST_CLEAR, ST_READY, ST_RECOVER} state_t;

  localparam logic [MAT_AW-1:0] VEC_LAST = MAT_AW'(VEC_DEPTH - 1);
  localparam logic [MAT_AW-1:0] MAT_LAST = MAT_AW'(MAT_DEPTH - 1);

  state_t            state, state_next;
  logic [MAT_AW-1:0] cnt, cnt_next;
  logic [1:0]        err, err_next;

  logic              vec_we;
  logic [VEC_AW-1:0] vec_addr;
  logic [DATA_W:0]   vec_wdata;
  logic [DATA_W:0]   vec_rdata;
  logic              mat_we;
  logic [MAT_AW-1:0] mat_addr;
  logic [1:0]        mat_wdata;
  logic              clear_wr_err;
  logic              parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      err   <= MEM_ERR_NONE;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    vec_we       = 1'b0;
    vec_addr     = mem_addr_a;
    vec_wdata    = {(^mem_wdata_a) ^ dbg_parity_flip, mem_wdata_a};
    mat_we       = 1'b0;
    mat_addr     = mem_addr_b;
    mat_wdata    = mem_wdata_b;
    clear_wr_err = 1'b0;

    case (state)
      ST_CLEAR: begin
        // The sweep owns both write ports; the vector RAM address returns to port A once
        // the sweep has passed the last vector word.
        mat_we    = 1'b1;
        mat_addr  = cnt;
        mat_wdata = '0;
        if (cnt <= VEC_LAST) begin
          vec_we    = 1'b1;
          vec_addr  = cnt[VEC_AW-1:0];
          vec_wdata = '0;
        end
        clear_wr_err = mem_we_a | mem_we_b;
        cnt_next     = cnt + 1'b1;
        if (cnt == MAT_LAST) state_next = ST_READY;
      end
      ST_READY: begin
        vec_we = mem_we_a;
        mat_we = mem_we_b;
        if (mem_we_a || mem_we_b) begin
          state_next = ST_RECOVER;
        end else if (clear_req) begin
          cnt_next   = '0;
          state_next = ST_CLEAR;
        end
      end
      ST_RECOVER: state_next = ST_READY;
      default:    state_next = ST_CLEAR;
    endcase
  end

  // The stored word carries even parity over data plus parity bit.
  assign parity_err = (state != ST_CLEAR) && (^vec_rdata);

  // A new error event in the same cycle as err_clear still leaves its flag set.
  always_comb begin
    err_next = err;
    if (err_clear)    err_next = MEM_ERR_NONE;
    if (clear_wr_err) err_next = err_next | MEM_ERR_CLEAR_WR;
    if (parity_err)   err_next = err_next | MEM_ERR_PARITY;
  end

  sp_ram_rbw #(.DEPTH(VEC_DEPTH), .WIDTH(DATA_W + 1)) u_vec_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (vec_we),
    .addr  (vec_addr),
    .wdata (vec_wdata),
    .rdata (vec_rdata)
  );

  sp_ram_rbw #(.DEPTH(MAT_DEPTH), .WIDTH(2)) u_mat_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mat_we),
    .addr  (mat_addr),
    .wdata (mat_wdata),
    .rdata (mem_rdata_b)
  );

  assign mem_rdata_a = vec_rdata[DATA_W-1:0];
  assign mem_busy    = (state != ST_READY);
  assign mem_error   = err;

endmodule

// File: tb/tb_shared_memory_bank.sv
// Directed bench for shared_memory_bank: clear sweep, writes, recovery, parity and error flags.
module tb_shared_memory_bank;
  import accel_pkg::*;

  localparam int DW = VECTOR_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    mem_addr_a;
  logic          mem_we_a;
  logic [DW-1:0] mem_wdata_a;
  logic [DW-1:0] mem_rdata_a;
  logic [7:0]    mem_addr_b;
  logic          mem_we_b;
  logic [1:0]    mem_wdata_b;
  logic [1:0]    mem_rdata_b;
  logic          mem_busy;
  logic [1:0]    mem_error;
  logic          clear_req;
  logic          err_clear;
  logic          dbg_parity_flip;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shared_memory_bank dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_addr_a      (mem_addr_a),
    .mem_we_a        (mem_we_a),
    .mem_wdata_a     (mem_wdata_a),
    .mem_rdata_a     (mem_rdata_a),
    .mem_addr_b      (mem_addr_b),
    .mem_we_b        (mem_we_b),
    .mem_wdata_b     (mem_wdata_b),
    .mem_rdata_b     (mem_rdata_b),
    .mem_busy        (mem_busy),
    .mem_error       (mem_error),
    .clear_req       (clear_req),
    .err_clear       (err_clear),
    .dbg_parity_flip (dbg_parity_flip)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_addr_a      = '0;
    mem_we_a        = 1'b0;
    mem_wdata_a     = '0;
    mem_addr_b      = '0;
    mem_we_b        = 1'b0;
    mem_wdata_b     = '0;
    clear_req       = 1'b0;
    err_clear       = 1'b0;
    dbg_parity_flip = 1'b0;
  endtask

  // Counts busy samples from the current one until busy drops (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (mem_busy === 1'b1 && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    vectors++; if (mem_busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy got=%b exp=1", mem_busy); end
    vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL reset_rdata_a got=%h exp=0", mem_rdata_a); end
    vectors++; if (mem_rdata_b !== 2'b00) begin miscompares++; $display("FAIL reset_rdata_b got=%b exp=00", mem_rdata_b); end
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL reset_error got=%b exp=00", mem_error); end
    tick();
    rst_n = 1'b1;
    count_busy(n);
    vectors++; if (n !== 256) begin miscompares++; $display("FAIL reset_sweep_len got=%0d exp=256", n); end
    tick(44);
    mem_addr_a = 6'd63;
    mem_addr_b = 8'd255;
    tick();
    vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL idle_vec63 got=%h exp=0", mem_rdata_a); end
    vectors++; if (mem_rdata_b !== 2'b00) begin miscompares++; $display("FAIL idle_mat255 got=%b exp=00", mem_rdata_b); end
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL idle_error got=%b exp=00", mem_error); end
  endtask

  task automatic test_write_ab();
    mem_addr_a = 6'd5;   mem_wdata_a = 32'hA5A5_0001; mem_we_a = 1'b1;
    mem_addr_b = 8'd200; mem_wdata_b = 2'b10;         mem_we_b = 1'b1;
    tick();
    mem_we_a = 1'b0; mem_we_b = 1'b0;
    vectors++; if (mem_busy !== 1'b1) begin miscompares++; $display("FAIL ab_busy_recover got=%b exp=1", mem_busy); end
    vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL ab_rbw_a got=%h exp=0", mem_rdata_a); end
    vectors++; if (mem_rdata_b !== 2'b00) begin miscompares++; $display("FAIL ab_rbw_b got=%b exp=00", mem_rdata_b); end
    tick();
    vectors++; if (mem_busy !== 1'b0) begin miscompares++; $display("FAIL ab_busy_ready got=%b exp=0", mem_busy); end
    vectors++; if (mem_rdata_a !== 32'hA5A5_0001) begin miscompares++; $display("FAIL ab_read_a got=%h exp=a5a50001", mem_rdata_a); end
    vectors++; if (mem_rdata_b !== 2'b10) begin miscompares++; $display("FAIL ab_read_b got=%b exp=10", mem_rdata_b); end
    tick();
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL ab_parity_ok got=%b exp=00", mem_error); end
  endtask

  task automatic test_back_to_back();
    mem_addr_a = 6'd6; mem_wdata_a = 32'h0000_0066; mem_we_a = 1'b1;
    tick();
    mem_addr_a = 6'd7; mem_wdata_a = 32'hDEAD_BEEF; mem_we_a = 1'b1;
    tick();
    mem_we_a = 1'b0;
    vectors++; if (mem_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got=%b exp=0", mem_busy); end
    tick();
    vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL b2b_vec7 got=%h exp=0", mem_rdata_a); end
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL b2b_error got=%b exp=00", mem_error); end
    mem_addr_a = 6'd8; mem_wdata_a = 32'h0000_0088; mem_we_a = 1'b1;
    tick();
    mem_we_a = 1'b0;
    vectors++; if (mem_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_busy got=%b exp=1", mem_busy); end
    mem_addr_a = 6'd6;
    tick();
    vectors++; if (mem_rdata_a !== 32'h0000_0066) begin miscompares++; $display("FAIL b2b_vec6 got=%h exp=66", mem_rdata_a); end
    mem_addr_a = 6'd8;
    tick();
    vectors++; if (mem_rdata_a !== 32'h0000_0088) begin miscompares++; $display("FAIL b2b_vec8 got=%h exp=88", mem_rdata_a); end
  endtask

  task automatic test_parity();
    mem_addr_a = 6'd3; mem_wdata_a = 32'h0000_0003; mem_we_a = 1'b1; dbg_parity_flip = 1'b1;
    tick();
    mem_we_a = 1'b0; dbg_parity_flip = 1'b0;
    tick();
    vectors++; if (mem_rdata_a !== 32'h0000_0003) begin miscompares++; $display("FAIL par_read got=%h exp=3", mem_rdata_a); end
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL par_not_yet got=%b exp=00", mem_error); end
    mem_addr_a = 6'd0;
    tick();
    vectors++; if (mem_error !== 2'b10) begin miscompares++; $display("FAIL par_flag got=%b exp=10", mem_error); end
    tick();
    vectors++; if (mem_error !== 2'b10) begin miscompares++; $display("FAIL par_sticky got=%b exp=10", mem_error); end
    mem_addr_a = 6'd3;
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (mem_error !== 2'b10) begin miscompares++; $display("FAIL par_clear_collision got=%b exp=10", mem_error); end
    mem_addr_a = 6'd0;
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL par_err_clear got=%b exp=00", mem_error); end
  endtask

  task automatic test_write_during_clear();
    int n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_addr_a = 6'd5;
    n = 0;
    while (mem_busy === 1'b1 && n < 400) begin
      if (n == 10) begin
        mem_wdata_a = 32'hFFFF_FFFF;
        mem_we_a    = 1'b1;
      end else begin
        mem_we_a = 1'b0;
      end
      n++;
      tick();
    end
    mem_we_a = 1'b0;
    vectors++; if (n !== 256) begin miscompares++; $display("FAIL clrwr_sweep_len got=%0d exp=256", n); end
    vectors++; if (mem_error !== 2'b01) begin miscompares++; $display("FAIL clrwr_error got=%b exp=01", mem_error); end
    tick();
    vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL clrwr_dropped got=%h exp=0", mem_rdata_a); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL clrwr_err_clear got=%b exp=00", mem_error); end
  endtask

  task automatic fill_data();
    mem_addr_a = 6'd1;  mem_wdata_a = 32'h1234_5678; mem_we_a = 1'b1;
    mem_addr_b = 8'd17; mem_wdata_b = 2'b11;         mem_we_b = 1'b1;
    tick();
    mem_we_a = 1'b0; mem_we_b = 1'b0;
    tick();
  endtask

  task automatic test_clear_req();
    int n;
    fill_data();
    mem_addr_a = 6'd2; mem_wdata_a = 32'h0000_0022; mem_we_a = 1'b1; clear_req = 1'b1;
    tick();
    mem_we_a = 1'b0; clear_req = 1'b0;
    vectors++; if (mem_busy !== 1'b1) begin miscompares++; $display("FAIL creq_wr_busy got=%b exp=1", mem_busy); end
    tick();
    vectors++; if (mem_busy !== 1'b0) begin miscompares++; $display("FAIL creq_dropped got=%b exp=0", mem_busy); end
    tick();
    vectors++; if (mem_rdata_a !== 32'h0000_0022) begin miscompares++; $display("FAIL creq_wr_data got=%h exp=22", mem_rdata_a); end
    mem_addr_a = 6'd1; mem_addr_b = 8'd17;
    tick();
    vectors++; if (mem_rdata_b !== 2'b11) begin miscompares++; $display("FAIL creq_filled_b got=%b exp=11", mem_rdata_b); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    count_busy(n);
    vectors++; if (n !== 256) begin miscompares++; $display("FAIL creq_sweep_len got=%0d exp=256", n); end
    tick();
    vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL creq_vec1 got=%h exp=0", mem_rdata_a); end
    vectors++; if (mem_rdata_b !== 2'b00) begin miscompares++; $display("FAIL creq_mat17 got=%b exp=00", mem_rdata_b); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic [7:0] a;
    fill_data();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(100);
    vectors++; if (mem_busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got=%b exp=1", mem_busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    count_busy(n);
    vectors++; if (n !== 256) begin miscompares++; $display("FAIL mid_sweep_len got=%0d exp=256", n); end
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      mem_addr_a = a[5:0];
      mem_addr_b = a;
      tick();
      if (i < 64) begin
        vectors++; if (mem_rdata_a !== '0) begin miscompares++; $display("FAIL mid_vec[%0d] got=%h exp=0", i, mem_rdata_a); end
      end
      vectors++; if (mem_rdata_b !== 2'b00) begin miscompares++; $display("FAIL mid_mat[%0d] got=%b exp=00", i, mem_rdata_b); end
    end
    vectors++; if (mem_error !== 2'b00) begin miscompares++; $display("FAIL mid_error got=%b exp=00", mem_error); end
  endtask

  initial begin
    test_reset();
    test_write_ab();
    test_back_to_back();
    test_parity();
    test_write_during_clear();
    test_clear_req();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
